// File: rtl/fifo_rd_stream.sv
// Read-side master for a synchronous FIFO: pops words, absorbs the 1-cycle read
// latency in a 2-entry skid buffer and streams them out on valid/ready.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

  occ_t                  state, state_nxt;
  logic                  pending;
  logic [FIFO_WIDTH-1:0] tail, head_nxt, tail_nxt;
  logic [2:0]            occ, credit;
  logic                  pop, land, drop;

  assign pop     = m_valid & m_ready;
  assign land    = pending & ~fifo_underflow;
  assign drop    = pending & fifo_underflow;
  assign m_valid = (state != EMPTY);

  always_comb begin
    occ = 3'd0;
    case (state)
      ONE:     occ = 3'd1;
      TWO:     occ = 3'd2;
      default: occ = 3'd0;
    endcase
  end

  // Slots not yet claimed by a buffered or in-flight word; a pop frees one now.
  assign credit     = 3'd2 - occ - {2'b0, pending} + {2'b0, pop};
  assign fifo_rd_en = rst_n & ~fifo_empty & (credit != 3'd0);

  always_comb begin
    state_nxt = state;
    head_nxt  = m_data;
    tail_nxt  = tail;
    case (state)
      EMPTY: begin
        if (land) begin
          head_nxt  = fifo_data_out;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (land && pop) begin
          head_nxt = fifo_data_out;
        end else if (land) begin
          tail_nxt  = fifo_data_out;
          state_nxt = TWO;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // Landing without a pop cannot happen here: credit was zero last cycle.
        if (pop) begin
          head_nxt = tail;
          if (land) tail_nxt = fifo_data_out;
          else      state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending       <= 1'b0;
      m_data        <= '0;
      tail          <= '0;
      beat_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      pending <= fifo_rd_en;
      m_data  <= head_nxt;
      tail    <= tail_nxt;
      if (pop)  beat_count    <= beat_count + 1'b1;
      if (drop) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO source and a scoreboard of words
// expected downstream, checked every cycle with immediate assertions.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic [15:0] beat_count;
  logic        err_underflow;

  fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .beat_count(beat_count), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [15:0] fq[$];     // words sitting in the FIFO
  logic [15:0] exp_q[$];  // words landed in the buffer, not yet delivered
  logic        pend = 1'b0;
  logic [15:0] pend_w = '0;
  logic [15:0] beats = '0;
  logic        err_m = 1'b0;
  logic        started = 1'b0, uf_arm = 1'b0, toggle = 1'b0;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;
  int          delivered = 0, rd_cnt = 0, cycnum = 0, first_rd = -1, first_vld = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: called just after a posedge, returns just after the next.
  task automatic cyc();
    logic        hs, rd, r, uf;
    logic [15:0] expw;
    if (toggle) m_ready = ~m_ready;
    fifo_empty = (fq.size() == 0);
    #4;
    cycnum++;
    rd = fifo_rd_en;
    if (rd) rd_cnt++;
    if (rd && first_rd < 0) first_rd = cycnum;
    if (m_valid === 1'b1 && first_vld < 0) first_vld = cycnum;
    if (fifo_empty || !rst_n) chk("rd_gate", fifo_rd_en, 0);
    hs = 1'b0;
    if (started) begin
      chk("m_valid", m_valid, exp_q.size() != 0);
      chk("beat_count", beat_count, beats);
      chk("err_underflow", err_underflow, err_m);
      if (stall_prev) chk("stall_hold", m_data, stall_data);
      hs = m_valid & m_ready;
      if (rd) chk("no_overflow", (exp_q.size() + pend + 1 - hs) <= 2, 1);
      if (hs) begin
        expw = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("m_data", m_data, expw);
        delivered++;
      end
    end
    stall_prev = started & rst_n & m_valid & ~m_ready;
    stall_data = m_data;
    r  = rst_n;
    uf = fifo_underflow;
    @(posedge clk);
    started = 1'b1;
    if (!r) begin
      exp_q.delete();
      pend  = 1'b0;
      beats = '0;
      err_m = 1'b0;
    end else begin
      if (hs) beats++;
      if (pend) begin
        if (uf) err_m = 1'b1;
        else    exp_q.push_back(pend_w);
      end
      pend = rd && fq.size() != 0;
      if (pend) pend_w = fq.pop_front();
    end
    #1;
    fifo_data_out  = pend ? pend_w : 16'($urandom);
    fifo_underflow = pend & uf_arm;
    if (fifo_underflow) uf_arm = 1'b0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fq.push_back(16'($urandom));
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && delivered < target; i++) cyc();
    chk("delivery_count", delivered, target);
  endtask

  initial begin
    int          base, rd0;
    logic [15:0] w0;
    rst_n = 1'b0; m_ready = 1'b0;
    fifo_data_out = '0; fifo_empty = 1'b1; fifo_underflow = 1'b0;
    @(posedge clk); #1;
    cyc(); cyc();
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_err", err_underflow, 0);
    rst_n = 1'b1;
    cyc();

    // Three words at full rate: first beat two cycles after the first read.
    m_ready = 1'b1; first_rd = -1; first_vld = -1;
    push_words(3);
    base = delivered;
    run_until(base + 3, 20);
    chk("first_latency", first_vld - first_rd, 2);
    chk("beat_count_3", beat_count, 3);

    // Stalled sink: exactly two reads fill the buffer, then a gap-free drain.
    m_ready = 1'b0; rd0 = rd_cnt;
    push_words(8);
    w0 = fq[0];
    repeat (6) cyc();
    chk("stall_reads", rd_cnt - rd0, 2);
    chk("stall_head", m_data, w0);
    m_ready = 1'b1; base = delivered;
    repeat (8) cyc();
    chk("no_gap_drain", delivered - base, 8);

    // Sink toggling every cycle.
    toggle = 1'b1; base = delivered;
    push_words(20);
    run_until(base + 20, 100);
    toggle = 1'b0; m_ready = 1'b1;
    repeat (3) cyc();

    // Underflow on one landing: that word drops, the error sticks.
    uf_arm = 1'b1; base = delivered;
    push_words(5);
    run_until(base + 4, 40);
    repeat (4) cyc();
    chk("err_sticky", err_underflow, 1);

    // Reset with words buffered and a read in flight.
    m_ready = 1'b0;
    push_words(4);
    cyc(); cyc();
    chk("pre_rst_valid", m_valid, 1);
    rst_n = 1'b0;
    cyc();
    chk("rst_mid_valid", m_valid, 0);
    chk("rst_mid_beats", beat_count, 0);
    chk("rst_mid_err", err_underflow, 0);
    cyc();
    rst_n = 1'b1; m_ready = 1'b1;
    base = delivered;
    run_until(base + 2, 20);
    repeat (3) cyc();

    // Counter wrap.
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    base = delivered;
    push_words(65540);
    run_until(base + 65535, 66000);
    chk("beat_ffff", beat_count, 16'hFFFF);
    run_until(base + 65536, 10);
    chk("beat_wrap", beat_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
